mdio_responder: RTL and testbench

- Synthesizable MDIO management slave (IEEE 802.3 clause 22): the responder end of the MDC/MDIO link that each Ethernet channel drives towards its KSZ9031 PHY.
- Oversamples MDC/MDIO in the system clock domain and decodes read and write frames against a 32x16 register file.
- Serves as a PHY stand-in for loopback benches and board bring-up without a physical PHY.

---
 rtl/mdio_pkg.sv | 13 +
 rtl/mdio_sync_edge.sv | 30 +++
 rtl/mdio_responder.sv | 186 ++++++++++++++++++
 tb/tb_mdio_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared FSM states, opcodes and register indices for the MDIO responder.
package mdio_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
   } state_t;
   localparam logic [1:0] OP_RD = 2'b10;
   localparam logic [1:0] OP_WR = 2'b01;
   localparam logic [4:0] REG_BMCR = 5'd0;
   localparam logic [4:0] REG_BMSR = 5'd1;
   localparam logic [4:0] REG_ID1 = 5'd2;
   localparam logic [4:0] REG_ID2 = 5'd3;
   localparam logic [15:0] BMSR_RST = 16'h7949;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: 2-FF synchronizers for MDC/MDIO with registered MDC rise/fall pulses.
// o_mdio is the MDIO sample aligned with the o_rise pulse.
module mdio_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_mdc,
   input  logic i_mdio,
   output logic o_rise,
   output logic o_fall,
   output logic o_mdio
);
   logic [1:0] r_mdc_s, r_mdio_s;
   logic       r_mdc_d;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_mdc_s  <= 2'b00;
         r_mdio_s <= 2'b11;
         r_mdc_d  <= 1'b0;
         o_mdio   <= 1'b1;
         o_rise   <= 1'b0;
         o_fall   <= 1'b0;
      end else begin
         r_mdc_s  <= {r_mdc_s[0], i_mdc};
         r_mdio_s <= {r_mdio_s[0], i_mdio};
         r_mdc_d  <= r_mdc_s[1];
         o_mdio   <= r_mdio_s[1];
         o_rise   <= r_mdc_s[1] & ~r_mdc_d;
         o_fall   <= ~r_mdc_s[1] & r_mdc_d;
      end
endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: clause-22 MDIO slave with a 32x16 register file, oversampled on sys_clk.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept frames after a single preamble 1 (BMSR bit6 = 1).
module mdio_responder
   import mdio_pkg::*;
#(
   parameter logic [4:0]  PHY_ADDR = 5'd1,
   parameter logic [15:0] PHY_ID1  = 16'h0022,
   parameter logic [15:0] PHY_ID2  = 16'h1622,
   parameter int          PRE_LEN  = 32
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        mdc,
   input  logic        mdio_i,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        link_up,
   output logic        wr_strobe,
   output logic [4:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        frame_err
);
   logic w_rise, w_fall, w_bit;
   state_t r_state, w_nxt;
   logic [4:0] r_bcnt, w_bcnt_nxt;
   logic [5:0] r_pre;
   logic w_err, w_last, w_pre_ok, w_wr_en, w_ta_drv, w_dat_drv;
   logic r_op, r_rd, r_wr, r_match, r_ta0, r_srst;
   logic [3:0] r_phy, r_reg;
   logic [4:0] r_addr;
   logic [14:0] r_sh;
   logic [15:0] r_rd_data, w_rd_val, w_wdata, w_bmsr;
   logic [1:0] w_op;
   logic [4:0] w_phy, w_reg;
   logic [15:0] r_regs [32];

   mdio_sync_edge u_sync (
      .i_clk  (sys_clk),
      .i_rst_n(sys_rst_n),
      .i_mdc  (mdc),
      .i_mdio (mdio_i),
      .o_rise (w_rise),
      .o_fall (w_fall),
      .o_mdio (w_bit)
   );

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam logic BMSR_PS = 1'b1;
   assign w_pre_ok = r_pre != 6'd0;
`else
   localparam logic BMSR_PS = 1'b0;
   localparam logic [5:0] PRE_MIN = 6'(PRE_LEN);
   assign w_pre_ok = r_pre >= PRE_MIN;
`endif

   assign w_last  = r_bcnt == 5'd0;
   assign w_op    = {r_op, w_bit};
   assign w_phy   = {r_phy, w_bit};
   assign w_reg   = {r_reg, w_bit};
   assign w_wdata = {r_sh, w_bit};
   assign w_bmsr  = {BMSR_RST[15:7], BMSR_PS, BMSR_RST[5:3], link_up, BMSR_RST[1:0]};
   assign w_rd_val = (w_reg == REG_BMSR) ? w_bmsr :
                     (w_reg == REG_ID1)  ? PHY_ID1 :
                     (w_reg == REG_ID2)  ? PHY_ID2 : r_regs[w_reg];
   assign w_wr_en = w_rise && r_state == S_DATA && w_last && r_wr &&
                    r_addr != REG_BMSR && r_addr != REG_ID1 && r_addr != REG_ID2;
   assign w_ta_drv  = r_state == S_TA && w_last && r_rd;
   assign w_dat_drv = r_state == S_DATA && r_rd;

   always_comb begin
      w_nxt = r_state;
      w_bcnt_nxt = r_bcnt - 5'd1;
      w_err = 1'b0;
      case (r_state)
         S_IDLE, S_PRE: begin
            w_nxt = (!w_bit && w_pre_ok) ? S_ST : S_PRE;
            w_bcnt_nxt = 5'd0;
         end
         S_ST: begin
            w_err = !w_bit;
            w_nxt = w_bit ? S_OP : S_IDLE;
            w_bcnt_nxt = 5'd1;
         end
         S_OP: if (w_last) begin
            w_err = w_op != OP_RD && w_op != OP_WR;
            w_nxt = w_err ? S_SKIP : S_PHYAD;
            w_bcnt_nxt = w_err ? 5'd27 : 5'd4;
         end
         S_PHYAD: if (w_last) begin
            w_nxt = S_REGAD;
            w_bcnt_nxt = 5'd4;
         end
         S_REGAD: if (w_last) begin
            w_nxt = r_match ? S_TA : S_SKIP;
            w_bcnt_nxt = r_match ? 5'd1 : 5'd17;
         end
         S_TA: if (w_last) begin
            w_err = r_wr && !(r_ta0 && !w_bit);
            w_nxt = w_err ? S_SKIP : S_DATA;
            w_bcnt_nxt = 5'd15;
         end
         S_DATA, S_SKIP: if (w_last) w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_state   <= S_IDLE;
         r_bcnt    <= 5'd0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= w_rise && w_err;
         if (w_rise) begin
            r_state <= w_nxt;
            r_bcnt  <= w_bcnt_nxt;
         end
      end

   // frame field capture, one bit per detected MDC rise
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_pre     <= 6'd0;
         r_op      <= 1'b0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_phy     <= 4'd0;
         r_match   <= 1'b0;
         r_reg     <= 4'd0;
         r_addr    <= 5'd0;
         r_rd_data <= 16'd0;
         r_ta0     <= 1'b0;
         r_sh      <= 15'd0;
      end else if (w_rise) begin
         if (r_state == S_IDLE || r_state == S_PRE)
            r_pre <= !w_bit ? 6'd0 : (r_pre == 6'd32) ? r_pre : r_pre + 6'd1;
         if (r_state == S_OP && !w_last) r_op <= w_bit;
         if (r_state == S_OP && w_last) begin
            r_rd <= w_op == OP_RD;
            r_wr <= w_op == OP_WR;
         end
         if (r_state == S_PHYAD) r_phy <= w_phy[3:0];
         if (r_state == S_PHYAD && w_last) r_match <= w_phy == PHY_ADDR;
         if (r_state == S_REGAD) r_reg <= w_reg[3:0];
         if (r_state == S_REGAD && w_last) begin
            r_addr    <= w_reg;
            r_rd_data <= w_rd_val;
         end
         if (r_state == S_TA && !w_last) r_ta0 <= w_bit;
         if (r_state == S_DATA) r_sh <= w_wdata[14:0];
      end

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         wr_strobe <= 1'b0;
         wr_addr   <= 5'd0;
         wr_data   <= 16'd0;
         r_srst    <= 1'b0;
      end else begin
         wr_strobe <= w_wr_en;
         r_srst    <= w_wr_en && r_addr == REG_BMCR && w_wdata[15];
         if (w_wr_en) begin
            wr_addr <= r_addr;
            wr_data <= w_wdata;
         end
      end

   // BMCR bit15 never stores; it triggers r_srst which clears the file next cycle
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 16'd0;
      end else if (r_srst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 16'd0;
      end else if (w_wr_en) begin
         r_regs[r_addr] <= (r_addr == REG_BMCR) ? {1'b0, w_wdata[14:0]} : w_wdata;
      end

   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         mdio_o  <= 1'b1;
         mdio_oe <= 1'b0;
      end else if (w_fall) begin
         mdio_oe <= w_ta_drv | w_dat_drv;
         mdio_o  <= w_dat_drv ? r_rd_data[r_bcnt[3:0]] : !w_ta_drv;
      end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: MDIO master model driving clause-22 frames, with a read-data scoreboard.
module tb_mdio_responder;
   logic sys_clk = 1'b0, sys_rst_n = 1'b0, mdc = 1'b0, link_up = 1'b1;
   logic m_oe = 1'b1, m_out = 1'b1;
   logic mdio_line, mdio_o, mdio_oe, wr_strobe, frame_err;
   logic [4:0] wr_addr;
   logic [15:0] wr_data;
   int checks = 0, errors = 0, strobe_cnt = 0, err_cnt = 0;
   logic [15:0] exp_q[$];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam logic [15:0] BMSR_UP = 16'h794D;
`else
   localparam logic [15:0] BMSR_UP = 16'h790D;
`endif

   assign mdio_line = mdio_oe ? mdio_o : (m_oe ? m_out : 1'b1);

   mdio_responder dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .mdc      (mdc),
      .mdio_i   (mdio_line),
      .mdio_o   (mdio_o),
      .mdio_oe  (mdio_oe),
      .link_up  (link_up),
      .wr_strobe(wr_strobe),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .frame_err(frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (wr_strobe) strobe_cnt++;
      if (frame_err) err_cnt++;
   end

   task automatic send_bit(input logic b, input logic drv, output logic s, output logic o);
      m_oe = drv;
      m_out = b;
      #80;
      s = mdio_line;
      o = mdio_oe;
      mdc = 1'b1;
      #80;
      mdc = 1'b0;
   endtask

   task automatic frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] ra, input logic [1:0] ta,
                        input logic [15:0] wd, input int stall,
                        output logic [15:0] rd, output logic oe_any, output logic ta_ok);
      logic s, o, rdop;
      logic [13:0] hdr;
      rdop = (op == 2'b10);
      hdr = {st, op, phy, ra};
      oe_any = 1'b0;
      ta_ok = 1'b0;
      rd = 16'h0;
      for (int i = 0; i < pre; i++) begin send_bit(1'b1, 1'b1, s, o); oe_any |= o; end
      for (int i = 13; i >= 0; i--) begin
         if (i == stall) #3000;
         send_bit(hdr[i], 1'b1, s, o);
         oe_any |= o;
      end
      send_bit(ta[1], !rdop, s, o); oe_any |= o;
      send_bit(ta[0], !rdop, s, o); oe_any |= o;
      ta_ok = o && s == 1'b0;
      for (int i = 15; i >= 0; i--) begin
         send_bit(wd[i], !rdop, s, o);
         oe_any |= o;
         rd[i] = s;
      end
      m_oe = 1'b1;
      m_out = 1'b1;
   endtask

   task automatic do_read(input int pre, input logic [4:0] ra, input logic [15:0] exp,
                          input int stall, output logic [15:0] rd, output logic ta_ok);
      logic oe;
      exp_q.push_back(exp);
      frame(pre, 2'b01, 2'b10, 5'd1, ra, 2'b11, 16'hFFFF, stall, rd, oe, ta_ok);
   endtask

   task automatic do_write(input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd);
      logic [15:0] rd;
      logic oe, tk;
      frame(32, 2'b01, 2'b01, 5'd1, ra, ta, wd, -1, rd, oe, tk);
   endtask

   task automatic test_reset();
      #23;
      checks++; if (mdio_o !== 1'b1) begin errors++; $display("FAIL reset_mdio_o: got %b want 1", mdio_o); end
      checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL reset_mdio_oe: got %b want 0", mdio_oe); end
      checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
      checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
      checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0000", wr_data); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      #10 sys_rst_n = 1'b1;
      @(negedge sys_clk);
      #2;
   endtask

   task automatic test_read_id();
      logic [15:0] rd, exp;
      logic tk;
      do_read(32, 5'd2, 16'h0022, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL read_id1: got %h want %h", rd, exp); end
      checks++; if (tk !== 1'b1) begin errors++; $display("FAIL read_ta_zero: got %b want 1", tk); end
      #100;
      checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL read_release: got %b want 0", mdio_oe); end
      do_read(40, 5'd3, 16'h1622, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL read_id2_long_pre: got %h want %h", rd, exp); end
   endtask

   task automatic test_bmsr();
      logic [15:0] rd, exp;
      logic tk;
      link_up = 1'b1;
      do_read(32, 5'd1, BMSR_UP, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL bmsr_link_up: got %h want %h", rd, exp); end
      link_up = 1'b0;
      do_read(32, 5'd1, BMSR_UP & ~16'h0004, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL bmsr_link_down: got %h want %h", rd, exp); end
      link_up = 1'b1;
   endtask

   task automatic test_write_read();
      logic [15:0] rd, exp;
      logic tk;
      int s0;
      s0 = strobe_cnt;
      do_write(5'd4, 2'b10, 16'h01E1);
      checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL write_strobe_cycles: got %0d want 1", strobe_cnt - s0); end
      checks++; if (wr_addr !== 5'd4) begin errors++; $display("FAIL write_addr: got %h want 04", wr_addr); end
      checks++; if (wr_data !== 16'h01E1) begin errors++; $display("FAIL write_data: got %h want 01e1", wr_data); end
      do_read(32, 5'd4, 16'h01E1, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL write_readback: got %h want %h", rd, exp); end
   endtask

   task automatic test_addr_mismatch();
      logic [15:0] rd, exp;
      logic oe, tk;
      frame(32, 2'b01, 2'b10, 5'd3, 5'd2, 2'b11, 16'hFFFF, -1, rd, oe, tk);
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL mismatch_oe: got %b want 0", oe); end
      do_read(32, 5'd4, 16'h01E1, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL mismatch_next_read: got %h want %h", rd, exp); end
   endtask

   task automatic test_ta_error();
      logic [15:0] rd, exp;
      logic tk;
      int s0, e0;
      s0 = strobe_cnt;
      e0 = err_cnt;
      do_write(5'd4, 2'b11, 16'hBEEF);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL ta_err_pulse: got %0d want 1", err_cnt - e0); end
      checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL ta_err_strobe: got %0d want %0d", strobe_cnt, s0); end
      do_read(32, 5'd4, 16'h01E1, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL ta_err_reg4: got %h want %h", rd, exp); end
   endtask

   task automatic test_ro_write();
      logic [15:0] rd, exp;
      logic tk;
      int s0;
      s0 = strobe_cnt;
      do_write(5'd2, 2'b10, 16'h1234);
      checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL ro_write_strobe: got %0d want %0d", strobe_cnt, s0); end
      do_read(32, 5'd2, 16'h0022, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL ro_write_id1: got %h want %h", rd, exp); end
   endtask

   task automatic test_bad_frames();
      logic [15:0] rd, exp;
      logic oe, tk;
      int s0, e0;
      e0 = err_cnt;
      frame(32, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 16'h0000, -1, rd, oe, tk);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL st_err_pulse: got %0d want 1", err_cnt - e0); end
      e0 = err_cnt;
      s0 = strobe_cnt;
      frame(32, 2'b01, 2'b11, 5'd1, 5'd4, 2'b10, 16'h1234, -1, rd, oe, tk);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL op_err_pulse: got %0d want 1", err_cnt - e0); end
      checks++; if (strobe_cnt != s0 || oe !== 1'b0) begin errors++; $display("FAIL op_err_quiet: got strobes %0d oe %b want 0 0", strobe_cnt - s0, oe); end
      do_read(32, 5'd4, 16'h01E1, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL op_err_reg4: got %h want %h", rd, exp); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd, exp;
      logic tk;
      do_write(5'd5, 2'b10, 16'hA5A5);
      do_read(32, 5'd5, 16'hA5A5, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL b2b_reg5: got %h want %h", rd, exp); end
      checks++; if (wr_addr !== 5'd5) begin errors++; $display("FAIL b2b_wr_addr: got %h want 05", wr_addr); end
      do_read(32, 5'd3, 16'h1622, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL b2b_read_read: got %h want %h", rd, exp); end
   endtask

   task automatic test_mdc_stall();
      logic [15:0] rd, exp;
      logic tk;
      do_read(32, 5'd4, 16'h01E1, 7, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL stall_read: got %h want %h", rd, exp); end
   endtask

   task automatic test_short_preamble();
      logic [15:0] rd, exp;
      logic oe, tk;
      frame(10, 2'b01, 2'b10, 5'd1, 5'd2, 2'b11, 16'hFFFF, -1, rd, oe, tk);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      checks++; if (rd !== 16'h0022) begin errors++; $display("FAIL short_pre_read: got %h want 0022", rd); end
`else
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL short_pre_ignored: got oe %b want 0", oe); end
`endif
      do_read(32, 5'd3, 16'h1622, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL short_pre_next: got %h want %h", rd, exp); end
   endtask

   task automatic test_soft_reset();
      logic [15:0] rd, exp;
      logic tk;
      do_write(5'd0, 2'b10, 16'h8000);
      checks++; if (wr_addr !== 5'd0 || wr_data !== 16'h8000) begin errors++; $display("FAIL srst_strobe: got %h/%h want 00/8000", wr_addr, wr_data); end
      do_read(32, 5'd4, 16'h0000, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL srst_reg4: got %h want %h", rd, exp); end
      do_read(32, 5'd0, 16'h0000, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL srst_reg0: got %h want %h", rd, exp); end
      do_read(32, 5'd5, 16'h0000, -1, rd, tk);
      exp = exp_q.pop_front();
      checks++; if (rd !== exp) begin errors++; $display("FAIL srst_reg5: got %h want %h", rd, exp); end
   endtask

   task automatic test_async_reset();
      logic [15:0] rd, exp, hdr_w;
      logic [13:0] hdr;
      logic s, o, tk;
      hdr = {2'b01, 2'b10, 5'd1, 5'd3};
      for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b1, s, o);
      for (int i = 13; i >= 0; i--) send_bit(hdr[i], 1'b1, s, o);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, s, o);
      #40;
      checks++; if (mdio_oe !== 1'b1) begin errors++; $display("FAIL arst_pre_drive: got %b want 1", mdio_oe); end
      #1 sys_rst_n = 1'b0;
      #1;
      checks++; if (mdio_oe !== 1'b0 || mdio_o !== 1'b1) begin errors++; $display("FAIL arst_release: got oe %b o %b want 0 1", mdio_oe, mdio_o); end
      #20 sys_rst_n = 1'b1;
      m_oe = 1'b1;
      @(negedge sys_clk);
      #2;
      do_read(32, 5'd2, 16'h0022, -1, rd, tk);
      exp = exp_q.pop_front();
      hdr_w = rd;
      checks++; if (hdr_w !== exp) begin errors++; $display("FAIL arst_next_read: got %h want %h", hdr_w, exp); end
   endtask

   initial begin
      test_reset();
      test_read_id();
      test_bmsr();
      test_write_read();
      test_addr_mismatch();
      test_ta_error();
      test_ro_write();
      test_bad_frames();
      test_back_to_back();
      test_mdc_stall();
      test_short_preamble();
      test_soft_reset();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
